// File: rtl/alu_wide_sequencer.sv
// Issues a WORDS x 32-bit operation to a 32-bit combinational ALU, one word per cycle, LSW first.
// Optional: define ALU_SEQ_PERF_CNT_EN to add the ops_done_cnt completed-response counter.
module alu_wide_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic                  req_cin,
  input  logic [32*WORDS-1:0]   req_a,
  input  logic [32*WORDS-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*WORDS-1:0]   rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_sign,
  output logic                  rsp_carry,
  output logic                  rsp_ovf,
  output logic                  rsp_illegal,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [5:0]            alu_opcode,
  output logic                  alu_cin,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_sign,
  input  logic                  alu_carry,
  input  logic                  alu_ovf
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]           ops_done_cnt
`endif
);

  localparam int unsigned DW    = 32 * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_CMP  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_ADDC = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_ADC = 6'b000001;
  localparam logic [5:0] ALU_SUB = 6'b000010;
  localparam logic [5:0] ALU_SBC = 6'b000011;
  localparam logic [5:0] ALU_AND = 6'b001000;
  localparam logic [5:0] ALU_OR  = 6'b001001;
  localparam logic [5:0] ALU_XOR = 6'b001010;
  localparam logic [5:0] ALU_NOP = 6'b111111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // ALU opcode for one word; chained ops switch to the carry-in form above word 0
  function automatic logic [5:0] word_opcode(input logic [2:0] op, input logic first);
    case (op)
      OP_ADD:         return first ? ALU_ADD : ALU_ADC;
      OP_ADDC:        return ALU_ADC;
      OP_SUB, OP_CMP: return first ? ALU_SUB : ALU_SBC;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_XOR:         return ALU_XOR;
      default:        return ALU_NOP;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [2:0]        op_q, op_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic              zacc_q, zacc_d;
  logic              req_ready_d, rsp_valid_d;
  logic [DW-1:0]     rsp_result_d;
  logic              rsp_zero_d, rsp_sign_d, rsp_carry_d, rsp_ovf_d, rsp_illegal_d;
  logic [31:0]       alu_a_d, alu_b_d;
  logic [5:0]        alu_opcode_d;
  logic              alu_cin_d;
  logic              is_rsv, is_arith;

  assign is_rsv   = (op_q == OP_RSV);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_ADDC) || (op_q == OP_SUB) || (op_q == OP_CMP);
  assign idx_nxt  = idx_q + IDX_W'(1);

  // Next-state and next-output logic; ALU-facing outputs are presented one word ahead
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    zacc_d        = zacc_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_result_d  = rsp_result;
    rsp_zero_d    = rsp_zero;
    rsp_sign_d    = rsp_sign;
    rsp_carry_d   = rsp_carry;
    rsp_ovf_d     = rsp_ovf;
    rsp_illegal_d = rsp_illegal;
    alu_a_d       = alu_a;
    alu_b_d       = alu_b;
    alu_opcode_d  = alu_opcode;
    alu_cin_d     = alu_cin;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d       = EXEC;
          op_d          = req_op;
          a_d           = req_a;
          b_d           = req_b;
          idx_d         = '0;
          zacc_d        = 1'b1;
          req_ready_d   = 1'b0;
          rsp_result_d  = '0;
          rsp_zero_d    = 1'b0;
          rsp_sign_d    = 1'b0;
          rsp_carry_d   = 1'b0;
          rsp_ovf_d     = 1'b0;
          rsp_illegal_d = 1'b0;
          alu_a_d       = req_a[31:0];
          alu_b_d       = req_b[31:0];
          alu_opcode_d  = word_opcode(req_op, 1'b1);
          alu_cin_d     = (req_op == OP_ADDC) && req_cin;
        end
      end

      EXEC: begin
        zacc_d = zacc_q & alu_zero;
        if (op_q != OP_CMP && !is_rsv)
          rsp_result_d[32*32'(idx_q) +: 32] = alu_result;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_zero_d    = is_rsv || (zacc_q && alu_zero);
          rsp_sign_d    = !is_rsv && alu_sign;
          rsp_carry_d   = is_arith && alu_carry;
          rsp_ovf_d     = is_arith && alu_ovf;
          rsp_illegal_d = is_rsv;
          alu_a_d       = '0;
          alu_b_d       = '0;
          alu_opcode_d  = ALU_NOP;
          alu_cin_d     = 1'b0;
        end else begin
          idx_d         = idx_nxt;
          alu_a_d       = a_q[32*32'(idx_nxt) +: 32];
          alu_b_d       = b_q[32*32'(idx_nxt) +: 32];
          alu_opcode_d  = word_opcode(op_q, 1'b0);
          alu_cin_d     = alu_carry;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      zacc_q      <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_sign    <= 1'b0;
      rsp_carry   <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= ALU_NOP;
      alu_cin     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      zacc_q      <= zacc_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_result  <= rsp_result_d;
      rsp_zero    <= rsp_zero_d;
      rsp_sign    <= rsp_sign_d;
      rsp_carry   <= rsp_carry_d;
      rsp_ovf     <= rsp_ovf_d;
      rsp_illegal <= rsp_illegal_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_opcode  <= alu_opcode_d;
      alu_cin     <= alu_cin_d;
    end
  end

`ifdef ALU_SEQ_PERF_CNT_EN
  // Completed responses, including reserved ops; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ops_done_cnt <= '0;
    else if (rsp_valid && rsp_ready)
      ops_done_cnt <= ops_done_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer: a behavioural 32-bit ALU feeds the DUT, and wide results are
// checked against whole-operand arithmetic. Covers ALU_SEQ_PERF_CNT_EN when defined.
module tb_alu_wide_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned DW = 32 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_cin;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero, rsp_sign, rsp_carry, rsp_ovf, rsp_illegal;
  logic [31:0]   alu_a, alu_b, alu_result;
  logic [5:0]    alu_opcode;
  logic          alu_cin, alu_zero, alu_sign, alu_carry, alu_ovf;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0]   ops_done_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .rsp_illegal(rsp_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .ops_done_cnt(ops_done_cnt)
`endif
  );

  // Behavioural 32-bit ALU; carry means borrow for the subtract opcodes
  logic [32:0] alu_t;
  always_comb begin
    alu_t   = '0;
    alu_ovf = 1'b0;
    case (alu_opcode)
      6'b000000: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      6'b000001: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_cin);
      6'b000010: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      6'b000011: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - 33'(alu_cin);
      6'b001000: alu_t = {1'b0, alu_a & alu_b};
      6'b001001: alu_t = {1'b0, alu_a | alu_b};
      6'b001010: alu_t = {1'b0, alu_a ^ alu_b};
      default:   alu_t = '0;
    endcase
    if (alu_opcode == 6'b000000 || alu_opcode == 6'b000001)
      alu_ovf = (alu_a[31] == alu_b[31]) && (alu_t[31] != alu_a[31]);
    else if (alu_opcode == 6'b000010 || alu_opcode == 6'b000011)
      alu_ovf = (alu_a[31] != alu_b[31]) && (alu_t[31] != alu_a[31]);
    alu_result = alu_t[31:0];
    alu_carry  = alu_t[32];
    alu_zero   = (alu_t[31:0] == 32'd0);
    alu_sign   = alu_t[31];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-operand reference: result and flags of the wide operation
  function automatic void ref_model(input logic [2:0] op, input logic cin,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] res, output logic z, output logic s,
                                    output logic c, output logic o, output logic il);
    logic [DW:0]   sum;
    logic [DW-1:0] val;
    c = 1'b0; o = 1'b0; il = 1'b0; val = '0;
    case (op)
      3'd0, 3'd6: begin
        sum = {1'b0, a} + {1'b0, b} + ((op == 3'd6) ? (DW+1)'(cin) : '0);
        val = sum[DW-1:0];
        c   = sum[DW];
        o   = (a[DW-1] == b[DW-1]) && (val[DW-1] != a[DW-1]);
      end
      3'd1, 3'd2: begin
        val = a - b;
        c   = (a < b);
        o   = (a[DW-1] != b[DW-1]) && (val[DW-1] != a[DW-1]);
      end
      3'd3: val = a & b;
      3'd4: val = a | b;
      3'd5: val = a ^ b;
      default: il = 1'b1;
    endcase
    z   = (val == '0);
    s   = val[DW-1];
    res = (op == 3'd2 || op == 3'd7) ? '0 : val;
  endfunction

  function automatic logic [5:0] exp_opcode(input logic [2:0] op, input int w);
    case (op)
      3'd0:       return (w == 0) ? 6'b000000 : 6'b000001;
      3'd6:       return 6'b000001;
      3'd1, 3'd2: return (w == 0) ? 6'b000010 : 6'b000011;
      3'd3:       return 6'b001000;
      3'd4:       return 6'b001001;
      3'd5:       return 6'b001010;
      default:    return 6'b111111;
    endcase
  endfunction

  // Carry/borrow expected into word w: computed from the low 32*w bits of the operands
  function automatic logic exp_cin(input logic [2:0] op, input logic cin,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b, input int w);
    logic [DW:0] one_v, mask, al, bl, sum;
    if (w == 0) return (op == 3'd6) && cin;
    if (op > 3'd2 && op != 3'd6) return 1'b0;
    one_v = 1;
    mask  = (one_v << (32 * w)) - 1;
    al    = {1'b0, a} & mask;
    bl    = {1'b0, b} & mask;
    if (op == 3'd1 || op == 3'd2) return al < bl;
    sum = al + bl + ((op == 3'd6) ? (DW+1)'(cin) : '0);
    return sum[32 * w];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic cin, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input int hold);
    logic [DW-1:0] er;
    logic ez, es, ec, eo, ei;
    int n;
    ref_model(op, cin, a, b, er, ez, es, ec, eo, ei);
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    check("alu_opcode_idle", alu_opcode, 6'b111111);
    req_valid = 1'b1; req_op = op; req_cin = cin; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    req_a = DW'({$urandom, $urandom, $urandom, $urandom});
    check("req_ready_busy", req_ready, 0);
    for (int w = 0; w < W; w++) begin
      check("rsp_valid_exec", rsp_valid, 0);
      check($sformatf("alu_opcode_w%0d", w), alu_opcode, exp_opcode(op, w));
      check($sformatf("alu_cin_w%0d", w), alu_cin, exp_cin(op, cin, a, b, w));
      check($sformatf("alu_a_w%0d", w), alu_a, a[32*w +: 32]);
      tick();
    end
    check("rsp_valid_latency", rsp_valid, 1);
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      check("rsp_result", rsp_result, er);
      check("rsp_flags", {rsp_zero, rsp_sign, rsp_carry, rsp_ovf, rsp_illegal},
            {ez, es, ec, eo, ei});
      check("rsp_valid_hold", rsp_valid, 1);
      check("req_ready_resp", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    check("rsp_valid_after", rsp_valid, 0);
    check("req_ready_after", req_ready, 1);
`ifdef ALU_SEQ_PERF_CNT_EN
    check("ops_done_cnt", ops_done_cnt, exp_cnt);
`endif
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      2:       return 32'h7FFF_FFFF ^ {31'd0, $urandom_range(0, 1) == 1};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [DW-1:0] ra, rb;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_cin = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    check("rst_alu_opcode", alu_opcode, 6'b111111);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    rst_n = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu_cin", alu_cin, 0);
`ifdef ALU_SEQ_PERF_CNT_EN
    check("rst_ops_done_cnt", ops_done_cnt, 0);
`endif

    run_op(3'd0, 1'b0, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'd1, 0);
    run_op(3'd1, 1'b0, 128'd0, 128'd1, 3);
    run_op(3'd0, 1'b0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 0);
    run_op(3'd2, 1'b0, 128'h12345678_9ABCDEF0_0F0F0F0F_00000001,
           128'h12345678_9ABCDEF0_0F0F0F0F_00000001, 1);
    run_op(3'd6, 1'b1, 128'd0, 128'd0, 0);
    run_op(3'd7, 1'b1, 128'h1234, 128'h5678, 2);
    run_op(3'd3, 1'b0, 128'hF0F0_0000_FFFF, 128'hFF00_FFFF_0F0F, 0);

    // Abort in the middle of word 2
    req_valid = 1'b1; req_op = 3'd0; req_a = '1; req_b = 128'd1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("abort_opcode_w2", alu_opcode, 6'b000001);
    #2 rst_n = 1'b0;
    #1;
    check("abort_alu_opcode", alu_opcode, 6'b111111);
    check("abort_alu_a", alu_a, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    check("abort_req_ready", req_ready, 1);
    for (int i = 0; i < W + 2; i++) begin
      check("abort_no_rsp", rsp_valid, 0);
      tick();
    end
`ifdef ALU_SEQ_PERF_CNT_EN
    check("abort_ops_done_cnt", ops_done_cnt, 0);
`endif
    run_op(3'd0, 1'b0, 128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF, 128'd5, 0);

    for (int i = 0; i < 40; i++) begin
      ra = {rand_word(), rand_word(), rand_word(), rand_word()};
      rb = {rand_word(), rand_word(), rand_word(), rand_word()};
      if (i % 5 == 0) rb = ra;
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
Multi-cycle issuer that drives the team's 32-bit combinational ALU to perform WORDS×32-bit wide operations, one 32-bit word per cycle, LSW first. It chains carry/borrow through the ALU's ADC/SBC opcodes and accumulates the wide flags. It sits between a valid/ready command source and the ALU's A/B/opcode/CarryIn inputs, and consumes the ALU's Result and flag outputs.

Parameters:
WORDS, 4, number of 32-bit words per operand (min 1, max 16)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&ready
req_op  input  3  000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 ADDC, 111 reserved
req_cin  input  1  carry-in, used by ADDC only
req_a  input  32*WORDS  operand A
req_b  input  32*WORDS  operand B
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when valid&ready
rsp_result  output  32*WORDS  wide result
rsp_zero  output  1  entire rsp_result (CMP: difference) is zero
rsp_sign  output  1  MSB of MSW result (CMP: of difference)
rsp_carry  output  1  final-word carry/borrow
rsp_ovf  output  1  final-word signed overflow
rsp_illegal  output  1  request op was 111
alu_a  output  32  to ALU A
alu_b  output  32  to ALU B
alu_opcode  output  6  to ALU opcode
alu_cin  output  1  to ALU CarryIn
alu_result  input  32  from ALU Result
alu_zero, alu_sign, alu_carry, alu_ovf  input  1 each  from ALU flags

Behaviour:
- Reset: all outputs and state clear (req_ready=1 after release, rsp_*=0, alu_a/alu_b=0, alu_opcode=6'b111111 NOP, alu_cin=0). Reset during any state aborts immediately; no response is produced for the aborted request.
- FSM: IDLE -> EXEC (on req handshake) -> RESP (after word WORDS-1) -> IDLE (on rsp handshake).
- IDLE: req_ready=1. ALU driven with NOP, A=B=0. On handshake, req_op, req_cin, req_a and req_b are registered, word index idx=0, and the zero accumulator is set to 1.
- EXEC: req_ready=0. alu_a/alu_b = word idx of the registered operands (combinational from registers). ALU is combinational, so alu_result and flags are sampled the same cycle, written into result word idx, and idx increments.
- Opcode map:
  - ADD: word0 000000, others 000001.
  - ADDC: all words 000001.
  - SUB/CMP: word0 000010, others 000011.
  - AND/OR/XOR: 001000/001001/001010.
  - Reserved: 111111.
- alu_cin: ADDC word0 = req_cin; otherwise word0 = 0; words ≥1 = alu_carry registered from the previous word (borrow for SUB/CMP).
- Zero accumulator ANDs alu_zero each word. Sign, carry and ovf are taken from the final word only.
- Logical ops: rsp_carry=rsp_ovf=0.
- CMP: rsp_result forced 0; flags reflect the difference.
- Reserved op: rsp_result=0, rsp_zero=1, rsp_sign/carry/ovf=0, rsp_illegal=1. Latency is unchanged.
- RESP: rsp_valid=1; all rsp_* held stable until rsp_ready. Handshake returns to IDLE; the next request is accepted no earlier than the following cycle.
- Latency: request accepted at edge T; rsp_valid asserts after edge T+WORDS. Throughput is one op per WORDS+2 cycles.
- WORDS=1: single EXEC cycle; chaining is unused.

Optional Feature:
ALU_SEQ_PERF_CNT_EN
- Defined: extra output ops_done_cnt[15:0], reset 0, increments on each rsp handshake, wraps 0xFFFF -> 0. Reserved ops are counted; aborted ops are not.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WORDS=4, ADD a=0x00000000_00000000_FFFFFFFF_FFFFFFFF, b=1 -> result 0x00000000_00000001_00000000_00000000, carry=0, ovf=0, zero=0; alu_opcode sequence 00,01,01,01; rsp_valid 4 cycles after accept edge.
- SUB a=0, b=1 -> result all 0xFFFFFFFF, carry=1, sign=1, ovf=0; alu_cin=1 on words 1-3.
- ADD a=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1 -> result 0x80000000_00000000_00000000_00000000, ovf=1, sign=1, carry=0; CMP a=b=0x12345678_9ABCDEF0_0F0F0F0F_00000001 -> result 0, zero=1, carry=0.
- ADDC req_cin=1, a=b=0 -> result 1, zero=0; op 111 -> result 0, zero=1, illegal=1, same latency, alu_opcode stays 111111.
- rsp_ready held low 3 cycles -> rsp_* stable and req_ready=0 throughout; second request accepted the cycle after handshake; with ALU_SEQ_PERF_CNT_EN, ops_done_cnt goes 0->1->2.
- rst_n pulsed low during EXEC word 2 -> outputs clear asynchronously, alu_opcode=111111, no rsp_valid; after release req_ready=1 and a new ADD completes correctly.
